// File: rtl/kpad_pkg.sv
// Shared constants and helpers for the 4x4 matrix-keypad scanner.
//   KP_ROWS/KP_COLS : matrix geometry
//   KP_CODE_W       : width of a key code (r*4+c)
//   KP_ROW_RESET    : row drive pattern after reset (row 0 active)
package kpad_pkg;

   localparam int unsigned KP_ROWS      = 4;
   localparam int unsigned KP_COLS      = 4;
   localparam int unsigned KP_KEYS      = KP_ROWS * KP_COLS;
   localparam int unsigned KP_CODE_W    = 4;
   localparam int unsigned KP_ROW_IDX_W = 2;
   localparam int unsigned KP_DB_CNT_W  = 3;

   localparam logic [KP_ROWS-1:0] KP_ROW_RESET = 4'b1110;

   // Active-low one-cold row drive for a given row index.
   function automatic logic [KP_ROWS-1:0] kp_row_drive(input logic [KP_ROW_IDX_W-1:0] idx);
      return ~(KP_ROWS'(1) << idx);
   endfunction

endpackage

// File: rtl/kpad_debounce.sv
// Per-key debouncer: a saturating agreement counter plus the debounced state.
//   clk, rst_n : clock, async active-low reset
//   sample_en  : one-cycle strobe when this key's row is sampled
//   raw        : sampled key level (1 = pressed)
//   state      : debounced key level
//   rise       : one-cycle pulse, registered, when state goes 0->1
module kpad_debounce
   import kpad_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_en,
   input  logic raw,
   output logic state,
   output logic rise
);

   logic [KP_DB_CNT_W-1:0] cnt;
   logic [KP_DB_CNT_W-1:0] cnt_nxt;
   logic                   state_nxt;
   logic                   rise_nxt;

   // Count disagreeing samples; flip state once DEBOUNCE of them arrive in a row.
   always_comb begin
      cnt_nxt   = cnt;
      state_nxt = state;
      rise_nxt  = 1'b0;
      if (sample_en) begin
         if (raw == state) begin
            cnt_nxt = '0;
         end else if (cnt + KP_DB_CNT_W'(1) == KP_DB_CNT_W'(DEBOUNCE)) begin
            state_nxt = raw;
            cnt_nxt   = '0;
            rise_nxt  = raw;
         end else begin
            cnt_nxt = cnt + KP_DB_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         state <= 1'b0;
         rise  <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         state <= state_nxt;
         rise  <= rise_nxt;
      end
   end

endmodule

// File: rtl/kpad_scan.sv
// 4x4 matrix-keypad scanner: walks active-low rows, samples synchronized
// columns once per scan tick, debounces every key and reports presses on a
// single-entry valid/ack channel with a sticky overflow flag.
//   clk, rst_n : clock, async active-low reset
//   row        : active-low row drive (one bit low)
//   col        : active-low column sense, asynchronous
//   keys       : debounced bitmap, bit r*4+c = pressed
//   key_valid  : press event pending; key_code holds r*4+c
//   key_ack    : consumer accepts the pending event
//   overflow   : sticky, a press event was dropped
// Limitation: 3-key rectangles ghost; the bitmap reports the matrix as sensed.
module kpad_scan
   import kpad_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 40000,
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [KP_ROWS-1:0]   row,
   input  logic [KP_COLS-1:0]   col,
   output logic [KP_KEYS-1:0]   keys,
   output logic                 key_valid,
   output logic [KP_CODE_W-1:0] key_code,
   input  logic                 key_ack,
   output logic                 overflow
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);

   logic [CNT_W-1:0]        tick_cnt;
   logic                    tick_c;
   logic [KP_COLS-1:0]      col_m;
   logic [KP_COLS-1:0]      col_s;
   logic [KP_ROW_IDX_W-1:0] row_idx;
   logic [KP_ROW_IDX_W-1:0] row_idx_nxt_c;
   logic [KP_KEYS-1:0]      rise;

   logic                    ev_any_c;
   logic                    ev_multi_c;
   logic [KP_CODE_W-1:0]    ev_code_c;
   logic                    accept_c;
   logic                    valid_nxt;
   logic [KP_CODE_W-1:0]    code_nxt;
   logic                    ovf_nxt;

   // Two-flop column synchronizer; idle (pulled-up) value is all ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_m <= '1;
         col_s <= '1;
      end else begin
         col_m <= col;
         col_s <= col_m;
      end
   end

   // Scan tick: one cycle in every SCAN_DIV.
   assign tick_c = (tick_cnt == CNT_W'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (tick_c) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CNT_W'(1);
      end
   end

   // Row walker: advance after the current row has been sampled.
   assign row_idx_nxt_c = row_idx + KP_ROW_IDX_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_idx <= '0;
         row     <= KP_ROW_RESET;
      end else if (tick_c) begin
         row_idx <= row_idx_nxt_c;
         row     <= kp_row_drive(row_idx_nxt_c);
      end
   end

   // One debouncer per key, strobed only when its own row is sampled.
   for (genvar k = 0; k < KP_KEYS; k++) begin : g_key
      kpad_debounce #(
         .DEBOUNCE (DEBOUNCE)
      ) u_db (
         .clk       (clk),
         .rst_n     (rst_n),
         .sample_en (tick_c && (row_idx == KP_ROW_IDX_W'(k / KP_COLS))),
         .raw       (~col_s[k % KP_COLS]),
         .state     (keys[k]),
         .rise      (rise[k])
      );
   end

   // Lowest-index rise wins; any further rise in the same cycle is dropped.
   always_comb begin
      ev_any_c   = 1'b0;
      ev_multi_c = 1'b0;
      ev_code_c  = '0;
      for (int unsigned k = 0; k < KP_KEYS; k++) begin
         if (rise[k]) begin
            if (ev_any_c) begin
               ev_multi_c = 1'b1;
            end else begin
               ev_any_c  = 1'b1;
               ev_code_c = KP_CODE_W'(k);
            end
         end
      end
   end

   // Single-entry event slot; an ack frees it in the same cycle a new event loads.
   always_comb begin
      valid_nxt = key_valid;
      code_nxt  = key_code;
      ovf_nxt   = overflow;
      accept_c  = key_valid & key_ack;
      if (ev_any_c) begin
         if (!key_valid || accept_c) begin
            valid_nxt = 1'b1;
            code_nxt  = ev_code_c;
         end else begin
            ovf_nxt = 1'b1;
         end
         if (ev_multi_c) begin
            ovf_nxt = 1'b1;
         end
      end else if (accept_c) begin
         valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_valid <= 1'b0;
         key_code  <= '0;
         overflow  <= 1'b0;
      end else begin
         key_valid <= valid_nxt;
         key_code  <= code_nxt;
         overflow  <= ovf_nxt;
      end
   end

endmodule
